// File: rtl/next_work_day.sv
// next_work_day: registered "N-th working day after today" calendar helper.
// A chain of seven identical step cells walks forward one working day per
// cell; the requested count selects a tap, and the result is wrapped into
// the month and registered. One-cycle latency, no handshake.

// One working-day step: from weekday w_in, move to the next working day
// strictly after it, accumulating calendar days travelled in d.
module nwd_step (
  input  logic [2:0] w_in,
  input  logic [3:0] d_in,
  output logic [2:0] w_out,
  output logic [3:0] d_out
);
  // Fri jumps 3 days, Sat 2, everything else 1; all land on a working day.
  always_comb begin
    w_out = 3'd1;
    d_out = d_in + 4'd1;
    case (w_in)
      3'd1, 3'd2, 3'd3, 3'd4: begin
        w_out = w_in + 3'd1;
        d_out = d_in + 4'd1;
      end
      3'd5: begin
        w_out = 3'd1;
        d_out = d_in + 4'd3;
      end
      3'd6: begin
        w_out = 3'd1;
        d_out = d_in + 4'd2;
      end
      default: begin
        w_out = 3'd1;
        d_out = d_in + 4'd1;
      end
    endcase
  end
endmodule

module next_work_day #(
  parameter int MONTH_DAYS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] tod_in,
  input  logic [2:0] N_in,
  input  logic [2:0] week_in,
  output logic [4:0] date_out,
  output logic [2:0] week_out
);
  localparam int STAGES = 7;
  localparam logic [5:0] MD = 6'(MONTH_DAYS);

  // Tap i holds the (i+1)-th working day strictly after today.
  logic [STAGES-1:0][2:0] st_w;
  logic [STAGES-1:0][3:0] st_d;

  nwd_step u_step0 (
    .w_in  (week_in),
    .d_in  (4'd0),
    .w_out (st_w[0]),
    .d_out (st_d[0])
  );

  genvar g;
  generate
    for (g = 1; g < STAGES; g++) begin : g_step
      nwd_step u_step (
        .w_in  (st_w[g-1]),
        .d_in  (st_d[g-1]),
        .w_out (st_w[g]),
        .d_out (st_d[g])
      );
    end
  endgenerate

  logic       is_work;
  logic       bad_in;
  logic [2:0] tap;
  logic [3:0] d_sel;
  logic [2:0] w_sel;
  logic [5:0] sum;
  logic [5:0] date_nx;
  logic [4:0] date_d;
  logic [2:0] week_d;

  // Select the tap. N=0 on a working day is today itself; N=0 on a weekend
  // is the next working day, which is exactly tap 0 (same as N=1).
  always_comb begin
    is_work = (week_in >= 3'd1) && (week_in <= 3'd5);
    bad_in  = (week_in == 3'd0) || (tod_in == 5'd0) || ({1'b0, tod_in} > MD);
    tap     = (N_in == 3'd0) ? 3'd0 : N_in - 3'd1;
    d_sel   = st_d[tap];
    w_sel   = st_w[tap];
    if (N_in == 3'd0 && is_work) begin
      d_sel = 4'd0;
      w_sel = week_in;
    end
    sum     = {1'b0, tod_in} + {2'b00, d_sel};
    date_nx = (sum > MD) ? sum - MD : sum;
    date_d  = date_nx[4:0];
    week_d  = w_sel;
    if (bad_in) begin
      date_d = 5'd0;
      week_d = 3'd0;
    end
  end

  // Output register; async clear discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_out <= 5'd0;
      week_out <= 3'd0;
    end else begin
      date_out <= date_d;
      week_out <= week_d;
    end
  end
endmodule

// File: tb/tb_next_work_day.sv
// Directed bench for next_work_day: hand-computed vectors, a day-by-day
// counting reference for the full sweep, and a MONTH_DAYS=31 instance.
module tb_next_work_day;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] tod_in = 5'd17;
  logic [2:0] N_in = 3'd5;
  logic [2:0] week_in = 3'd3;
  logic [4:0] date_out, date31;
  logic [2:0] week_out, week31;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  next_work_day #(.MONTH_DAYS(30)) dut (
    .clk(clk), .rst_n(rst_n), .tod_in(tod_in), .N_in(N_in),
    .week_in(week_in), .date_out(date_out), .week_out(week_out)
  );

  next_work_day #(.MONTH_DAYS(31)) dut31 (
    .clk(clk), .rst_n(rst_n), .tod_in(tod_in), .N_in(N_in),
    .week_in(week_in), .date_out(date31), .week_out(week31)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walk forward one calendar day at a time counting working days.
  function automatic int ref_d(input int w, input int n);
    int d, cnt, wk;
    if (n == 0) return (w <= 5) ? 0 : (w == 6 ? 2 : 1);
    d = 0; cnt = 0; wk = w;
    while (cnt < n) begin
      d++;
      wk = (wk == 7) ? 1 : wk + 1;
      if (wk <= 5) cnt++;
    end
    return d;
  endfunction

  function automatic int ref_date(input int t, input int w, input int n, input int md);
    int s;
    if (w == 0 || t == 0 || t > md) return 0;
    s = t + ref_d(w, n);
    return (s > md) ? s - md : s;
  endfunction

  function automatic int ref_week(input int t, input int w, input int n, input int md);
    if (w == 0 || t == 0 || t > md) return 0;
    return ((w - 1 + ref_d(w, n)) % 7) + 1;
  endfunction

  // Drive on the falling edge, check just after the following rising edge.
  task automatic apply(input int t, input int w, input int n);
    @(negedge clk);
    tod_in  = 5'(t);
    week_in = 3'(w);
    N_in    = 3'(n);
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input int t, input int w, input int n,
                     input int exp_date, input int exp_week);
    apply(t, w, n);
    chk({tag, "_date"}, int'(date_out), exp_date);
    chk({tag, "_week"}, int'(week_out), exp_week);
  endtask

  initial begin
    // Reset held across edges with arbitrary inputs.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_date", int'(date_out), 0);
    chk("rst_week", int'(week_out), 0);
    chk("rst_date31", int'(date31), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, MONTH_DAYS=30, tod=30.
    vec("mon_n1",  30, 1, 1, 1, 2);
    vec("mon_n0",  30, 1, 0, 30, 1);
    vec("fri_n1",  30, 5, 1, 3, 1);
    vec("fri_n7",  30, 5, 7, 11, 2);
    vec("sat_n0",  30, 6, 0, 2, 1);
    vec("sun_n0",  30, 7, 0, 1, 1);
    vec("sat_n1",  30, 6, 1, 2, 1);
    vec("wed_n3",  10, 3, 3, 15, 1);
    vec("wk0",     30, 0, 2, 0, 0);
    vec("tod0",     0, 2, 2, 0, 0);
    vec("tod31",   31, 1, 1, 0, 0);
    chk("tod31_md31_date", int'(date31), 1);
    chk("tod31_md31_week", int'(week31), 2);

    // Full sweep, a new vector every cycle, both tod values, both months.
    for (int t = 0; t < 2; t++) begin
      for (int w = 1; w <= 7; w++) begin
        for (int n = 0; n <= 7; n++) begin
          int td;
          td = (t == 0) ? 30 : 10;
          apply(td, w, n);
          chk("sweep_date", int'(date_out), ref_date(td, w, n, 30));
          chk("sweep_week", int'(week_out), ref_week(td, w, n, 30));
          chk("sweep_wkrng", int'(week_out >= 3'd1 && week_out <= 3'd5), 1);
          chk("sweep31_date", int'(date31), ref_date(td, w, n, 31));
          chk("sweep31_week", int'(week31), ref_week(td, w, n, 31));
        end
      end
    end

    // Asynchronous reset mid-run: outputs clear with no clock edge.
    apply(30, 5, 7);
    chk("pre_arst_date", int'(date_out), 11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_date", int'(date_out), 0);
    chk("arst_week", int'(week_out), 0);
    chk("arst_date31", int'(date31), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_rst", 28, 4, 2, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
